// File: rtl/alu_result_fifo_if.sv
// Handshake and status bundle between the ALU result FIFO and its producer/consumer.
interface alu_result_fifo_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DROP_W = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [3:0]        in_flags;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W+3:0] out_data;
  logic [CNT_W-1:0]  count;
  logic [DROP_W-1:0] drop_cnt;
  logic [3:0]        sticky_flags;
  logic              sticky_clr;

  modport master (
    output in_valid, in_result, in_flags, out_ready, sticky_clr,
    input  in_ready, out_valid, out_data, count, drop_cnt, sticky_flags
  );

  modport slave (
    input  in_valid, in_result, in_flags, out_ready, sticky_clr,
    output in_ready, out_valid, out_data, count, drop_cnt, sticky_flags
  );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO for ALU result/flag words, with a saturating drop counter.
// Define ALU_FIFO_STICKY_EN to build the sticky OR-accumulated flag register.
module alu_result_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DROP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  alu_result_fifo_if.slave    bus
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CNT_W    = AW + 1;
  localparam int unsigned ENTRY_W  = DATA_W + 4;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic [DROP_W-1:0]  r_drop;

  logic w_full;
  logic w_empty;
  logic w_in_ready;
  logic w_push;
  logic w_pop;
  logic w_drop;
  logic w_clr;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  // in_ready deliberately ignores out_ready: a slot freed by a pop is reusable next cycle
  assign w_in_ready = ena & ~w_full;
  assign w_push     = ena & bus.in_valid & w_in_ready;
  assign w_drop     = ena & bus.in_valid & ~w_in_ready;
  assign w_pop      = ena & ~w_empty & bus.out_ready;
  assign w_clr      = ena & bus.sticky_clr;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = w_empty ? '0 : r_mem[r_rptr];
  assign bus.count     = r_count;
  assign bus.drop_cnt  = r_drop;

  // Storage is data-only; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {bus.in_flags, bus.in_result};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A clear coinciding with a drop leaves that drop counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else if (w_clr) begin
      r_drop <= w_drop ? DROP_W'(1) : '0;
    end else if (w_drop && (r_drop != DROP_MAX)) begin
      r_drop <= r_drop + DROP_W'(1);
    end
  end

`ifdef ALU_FIFO_STICKY_EN
  logic [3:0] r_sticky;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sticky <= '0;
    end else if (w_clr) begin
      r_sticky <= w_push ? bus.in_flags : 4'h0;
    end else if (w_push) begin
      r_sticky <= r_sticky | bus.in_flags;
    end
  end

  assign bus.sticky_flags = r_sticky;
`else
  assign bus.sticky_flags = 4'h0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: a queue scoreboard checks every popped head word.
module tb_alu_result_fifo;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned DROP_W = 4;

`ifdef ALU_FIFO_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic ena;

  alu_result_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DROP_W(DROP_W)) bus ();

  alu_result_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DROP_W(DROP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] res, input logic [3:0] fl);
    bus.in_valid  = v;
    bus.in_result = res;
    bus.in_flags  = fl;
  endtask

  function automatic logic [3:0] sticky_exp(input logic [3:0] v);
    return STICKY ? v : 4'h0;
  endfunction

  // Scoreboard: record accepted pushes, compare the head on every accepted pop.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("count_vs_model", 32'(bus.count), 32'(exp_q.size()));
      if (ena && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_with_empty_model", 32'(bus.out_valid), 32'd0);
        end else begin
          chk("head_data", 32'(bus.out_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (ena && bus.in_valid && bus.in_ready)
        exp_q.push_back({bus.in_flags, bus.in_result});
    end
  end

  initial begin
    rst_n          = 1'b0;
    ena            = 1'b1;
    bus.out_ready  = 1'b0;
    bus.sticky_clr = 1'b0;
    drive(1'b1, 4'h5, 4'h1);

    // Reset held two cycles with in_valid high
    cycle();
    cycle();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'h00);
    chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
    chk("rst_sticky", 32'(bus.sticky_flags), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    cycle();
    chk("first_push_valid", 32'(bus.out_valid), 32'd1);
    chk("first_push_data", 32'(bus.out_data), 32'h15);
    drive(1'b0, 4'h0, 4'h0);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    chk("first_drain_valid", 32'(bus.out_valid), 32'd0);
    bus.sticky_clr = 1'b1;
    cycle();
    bus.sticky_clr = 1'b0;
    chk("clr_sticky", 32'(bus.sticky_flags), 32'd0);

    // Fill to full
    drive(1'b1, 4'h3, 4'h0); cycle();
    drive(1'b1, 4'h7, 4'h1); cycle();
    drive(1'b1, 4'hA, 4'h2); cycle();
    drive(1'b1, 4'hF, 4'h8); cycle();
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fill_sticky", 32'(bus.sticky_flags), 32'(sticky_exp(4'hB)));

    // Overflow: 20 rejected pushes saturate the drop counter
    drive(1'b1, 4'hE, 4'h0);
    for (int i = 0; i < 20; i++) cycle();
    drive(1'b0, 4'h0, 4'h0);
    chk("drop_saturated", 32'(bus.drop_cnt), 32'd15);
    chk("overflow_count", 32'(bus.count), 32'd4);
    chk("overflow_head", 32'(bus.out_data), 32'h03);

    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    bus.out_ready = 1'b0;
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_data_zero", 32'(bus.out_data), 32'h00);
    bus.sticky_clr = 1'b1;
    cycle();
    bus.sticky_clr = 1'b0;
    chk("clr_drop", 32'(bus.drop_cnt), 32'd0);
    chk("clr_sticky2", 32'(bus.sticky_flags), 32'd0);

    // Steady push/pop at count 2 across pointer wrap
    drive(1'b1, 4'h0, 4'h0); cycle();
    drive(1'b1, 4'h1, 4'h0); cycle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'(i + 2), 4'h0);
      cycle();
      chk("pushpop_count", 32'(bus.count), 32'd2);
    end
    drive(1'b0, 4'h0, 4'h0);
    cycle();
    cycle();
    bus.out_ready = 1'b0;
    chk("wrap_drain_count", 32'(bus.count), 32'd0);

    // Reset mid-operation discards entries
    drive(1'b1, 4'h7, 4'h7); cycle(); cycle();
    drive(1'b0, 4'h0, 4'h0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_sticky", 32'(bus.sticky_flags), 32'd0);

    // Sticky accumulation and clear-with-push
    drive(1'b1, 4'h1, 4'h4); cycle();
    drive(1'b1, 4'h2, 4'h1); cycle();
    chk("sticky_or", 32'(bus.sticky_flags), 32'(sticky_exp(4'h5)));
    drive(1'b1, 4'h3, 4'h8);
    bus.sticky_clr = 1'b1;
    cycle();
    bus.sticky_clr = 1'b0;
    chk("sticky_clr_push", 32'(bus.sticky_flags), 32'(sticky_exp(4'h8)));
    chk("sticky_clr_drop", 32'(bus.drop_cnt), 32'd0);
    drive(1'b1, 4'h4, 4'h0); cycle();
    chk("refill_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 4'h9, 4'h9); cycle(); cycle();
    drive(1'b0, 4'h0, 4'h0);
    chk("two_drops", 32'(bus.drop_cnt), 32'd2);

    // ena low freezes everything
    ena            = 1'b0;
    bus.out_ready  = 1'b1;
    bus.sticky_clr = 1'b1;
    drive(1'b1, 4'h6, 4'hF);
    for (int i = 0; i < 5; i++) cycle();
    chk("ena0_in_ready", 32'(bus.in_ready), 32'd0);
    chk("ena0_count", 32'(bus.count), 32'd4);
    chk("ena0_drop", 32'(bus.drop_cnt), 32'd2);
    chk("ena0_sticky", 32'(bus.sticky_flags), 32'(sticky_exp(4'h8)));
    chk("ena0_head", 32'(bus.out_data), 32'h41);
    drive(1'b0, 4'h0, 4'h0);
    bus.sticky_clr = 1'b0;
    ena            = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    bus.out_ready = 1'b0;
    cycle();
    chk("final_empty", 32'(bus.out_valid), 32'd0);
    chk("model_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the 4-bit ALU wrapper. Captures each ALU result word and its four status flags (Carry, Zero, Negative, Overflow) into a small first-word-fall-through FIFO.
- A consumer (readout logic or host pins) drains entries with a valid/ready handshake.
- Also keeps sticky OR-accumulated flags and a saturating count of dropped results, so bursts of ALU operations can be inspected later.

Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, at least 2.
- DATA_W, 4, ALU result width in bits.
- DROP_W, 4, width of the saturating dropped-result counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  synchronous, active-low reset
- ena  input  1  design enable; when low, no push, no pop, no counter update
- in_valid  input  1  ALU result present this cycle
- in_ready  output  1  FIFO can accept; equals ena & !full
- in_result  input  DATA_W  ALU_Out
- in_flags  input  4  {Carry, Zero, Negative, Overflow}
- out_valid  output  1  head entry available; equals !empty
- out_ready  input  1  consumer accepts head entry
- out_data  output  DATA_W+4  {flags[3:0], result}; head entry when non-empty, all zeros when empty
- count  output  clog2(DEPTH)+1  current number of entries
- drop_cnt  output  DROP_W  saturating count of rejected pushes
- sticky_flags  output  4  OR of flags of all accepted entries since the last clear
- sticky_clr  input  1  clears sticky_flags and drop_cnt

Behaviour:
- Reset (rst_n low at a rising edge) forces:
  - read pointer, write pointer and count = 0
  - drop_cnt = 0 and sticky_flags = 0
  - out_valid = 0 and out_data = 0
  - in_ready = ena
  - Reset takes priority over every other input. Reset mid-operation discards all entries, with no partial state kept.
- push = ena & in_valid & in_ready
  - Writes {in_flags, in_result} at the write pointer, then increments the write pointer modulo DEPTH.
- pop = ena & out_valid & out_ready
  - Increments the read pointer modulo DEPTH.
- Latency:
  - A pushed entry appears on out_data/out_valid in the cycle after the push edge, including when the FIFO was empty. There is no same-cycle bypass.
  - Storage is registered; the head read is combinational from storage.
- count:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - full = (count == DEPTH); empty = (count == 0)
- Full FIFO:
  - in_ready = 0.
  - A pop in the same cycle frees a slot, but a push is not accepted until the next cycle (in_ready is not combinationally dependent on out_ready).
- Empty FIFO: out_valid = 0, and out_ready is ignored.
- Drop:
  - When ena & in_valid & !in_ready, drop_cnt increments and saturates at 2^DROP_W - 1.
  - When ena = 0 no drop is counted.
- Sticky flags:
  - On a push, sticky_flags |= in_flags.
  - sticky_clr (gated by ena) clears sticky_flags and drop_cnt.
  - If sticky_clr and a push occur in the same cycle, sticky_flags = in_flags of the new entry.
  - If sticky_clr and a drop occur in the same cycle, drop_cnt = 1.
- ena = 0 freezes all state. Outputs keep presenting the current head; in_ready = 0.
- Pointer wrap-around is seamless; the FIFO order is preserved across wrap.

Optional Feature:
- Macro: ALU_FIFO_STICKY_EN
- Defined: sticky_flags and sticky_clr behave as described in Behaviour.
- Not defined:
  - The sticky register is not built and sticky_flags is tied to 0.
  - sticky_clr still clears drop_cnt.

Test Plan:
1. Reset:
   - Stimulus: hold rst_n = 0 for 2 cycles with in_valid = 1, then release.
   - Required: count = 0, out_valid = 0, out_data = 0x00, drop_cnt = 0, sticky_flags = 0. The first push after release appears on out_data one cycle later.
2. Fill and drain:
   - Stimulus: push results 0x3, 0x7, 0xA, 0xF with flags 0x0, 0x1, 0x2, 0x8 (DEPTH = 4).
   - Required: count = 4, in_ready = 0. With out_ready = 1, out_data reads 0x03, 0x17, 0x2A, 0x8F in order, then out_valid = 0.
3. Overflow drop:
   - Stimulus: with the FIFO full, hold in_valid = 1 for 20 cycles.
   - Required: drop_cnt = 15 (saturated), FIFO contents unchanged, and the entry pushed first is still at the head.
4. Simultaneous push/pop with wrap-around:
   - Stimulus: keep count = 2 and push/pop every cycle for 10 cycles, incrementing the result from 0x0.
   - Required: count stays 2, and the output sequence is 0x0, 0x1, 0x2 ... with no loss across pointer wrap.
5. Sticky flags (ALU_FIFO_STICKY_EN defined):
   - Stimulus: push flags 0x4, then 0x1.
   - Required: sticky_flags = 0x5.
   - Stimulus: assert sticky_clr together with a push of flags 0x8.
   - Required: sticky_flags = 0x8 and drop_cnt = 0.
   - Without the macro, sticky_flags stays 0x0 throughout.
6. ena gating:
   - Stimulus: with ena = 0, assert in_valid, out_ready and sticky_clr for 5 cycles.
   - Required: count, pointers, drop_cnt and sticky_flags are unchanged; in_ready = 0; out_data holds the current head.
